fb_fwd_ctrl: RTL and testbench
==============================

FB_FWD_CTRL -- requirements
Module: fb_fwd_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the load-use stall counter.
REQ-002 SHALL have port clk input 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n input 1: reset, synchronous and active-low.
REQ-004 SHALL have port id_valid input 1: ID-stage instruction is valid.
REQ-005 SHALL have ports id_rs1, id_rs2, id_rd input 5 each: ID-stage source and destination register indices.
REQ-006 SHALL have ports id_regwrite and id_memread input 1 each: ID instruction writes rd, and is a load.
REQ-007 SHALL have port mem_ready input 1: data memory has completed the load in MEM.
REQ-008 SHALL have port branch_flush input 1: EX-stage redirect; kills the ID and EX instructions.
REQ-009 SHALL have ports fwd_a_sel and fwd_b_sel output 2 each: select codes for the rs1/rs2 EX forwarding muxes.
REQ-010 SHALL have ports stall_if and stall_id output 1 each: hold PC and IF/ID.
REQ-011 SHALL have port freeze output 1: hold all pipeline registers.
REQ-012 SHALL have port bubble_ex output 1: load a NOP into ID/EX.
REQ-013 SHALL have port lu_stall_cnt output CNT_W: count of load-use stall cycles.

Function
REQ-014 SHALL keep stage records EX, MEM and WB, each holding {valid, rd, regwrite, memread}; EX also holds rs1 and rs2.
REQ-015 SHALL advance the records each cycle when no stall applies: ID→EX→MEM→WB.
REQ-016 SHALL encode select codes as 00 = register file, 10 = EX/MEM ALU result, 01 = MEM/WB data.
REQ-017 SHALL drive fwd_x_sel = 10 when MEM.valid, MEM.regwrite, MEM.rd != 0 and MEM.rd == EX.rsx.
REQ-018 SHALL otherwise drive fwd_x_sel = 01 when WB.valid, WB.regwrite, WB.rd != 0 and WB.rd == EX.rsx.
REQ-019 SHALL otherwise drive fwd_x_sel = 00; EX/MEM takes priority over MEM/WB when both match.
REQ-020 SHALL make the select outputs combinational from the registered records, so they are valid in the same cycle the instruction sits in EX.
REQ-021 SHALL detect load-use when id_valid, EX.valid, EX.memread, EX.rd != 0, and EX.rd equals id_rs1 or id_rs2.
REQ-022 SHALL implement FSM states RUN, LU_STALL and MEM_WAIT.
REQ-023 RUN→LU_STALL on load-use: in that cycle assert stall_if, stall_id and bubble_ex; EX becomes invalid; ID is held.
REQ-024 LU_STALL SHALL last exactly one cycle, then return to RUN; the held instruction then receives select 01 from WB.
REQ-025 Any state→MEM_WAIT when MEM.valid, MEM.memread and !mem_ready: assert freeze and stall_if/stall_id; no record changes.
REQ-026 MEM_WAIT→RUN in the cycle after mem_ready = 1; freeze deasserts in the same cycle mem_ready rises.
REQ-027 SHALL give freeze priority over all else: branch_flush and load-use are ignored while frozen (the source holds branch_flush).
REQ-028 SHALL give branch_flush priority over load-use: on flush, ID is not stalled, EX and the incoming ID record become invalid, and no LU count occurs.
REQ-029 SHALL increment lu_stall_cnt by 1 per cycle in LU_STALL, saturating at all-ones (no wrap).
REQ-030 SHALL treat rd = x0 as never producing a hazard or a forward.

Reset
REQ-031 On rst_n = 0 at a clock edge: FSM = RUN, all record valid bits = 0, fields = 0, lu_stall_cnt = 0.
REQ-032 During and after reset, outputs SHALL be: fwd sels 00, stall_if/stall_id/freeze/bubble_ex 0.
REQ-033 Reset asserted mid-stall or mid-MEM_WAIT SHALL abort it in one cycle without a spurious count.

Structure
REQ-034 Select codes FB_FWD_REG/FB_FWD_ALU/FB_FWD_MEM and the FSM state encodings SHALL live in the shared fb_defines.v.
REQ-035 A sub-module fb_fwd_cmp (rs, MEM record, WB record → 2-bit sel) SHALL be instantiated twice, for operands a and b.

Verification
REQ-036 Sequence add x5 followed directly by sub x6 = x5 + x5 -> fwd_a_sel = fwd_b_sel = 10 while sub is in EX.
REQ-037 Sequence add x5, nop, or x7 = x5 -> fwd_a_sel = 01; MEM and WB both writing x5 -> 10.
REQ-038 Sequence lw x5 then add x6 = x5 -> one cycle with stall_if = stall_id = bubble_ex = 1, then fwd_a_sel = 01, and lu_stall_cnt = 1.
REQ-039 Load in MEM with mem_ready low for 3 cycles -> freeze high for exactly 3 cycles, records unchanged, then resume.
REQ-040 Load-use coincident with branch_flush -> no stall, EX invalid, count unchanged; writes to x0 -> selects stay 00.
REQ-041 Force lu_stall_cnt to all-ones and trigger a load-use -> counter holds at all-ones; rst_n low in MEM_WAIT -> RUN and all outputs 0 next cycle.

Source files
------------

// File: rtl/fb_fwd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fb_fwd_ctrl_pkg
// Shared definitions for the forwarding / hazard controller:
//   - forwarding mux select codes (register file, EX/MEM ALU result, MEM/WB data)
//   - controller FSM state encodings
//   - pipeline stage record types
// -----------------------------------------------------------------------------
package fb_fwd_ctrl_pkg;

  localparam logic [1:0] FB_FWD_REG = 2'b00;  // operand from register file
  localparam logic [1:0] FB_FWD_ALU = 2'b10;  // operand from EX/MEM ALU result
  localparam logic [1:0] FB_FWD_MEM = 2'b01;  // operand from MEM/WB data

  typedef enum logic [1:0] {
    FB_ST_RUN      = 2'd0,
    FB_ST_LU_STALL = 2'd1,
    FB_ST_MEM_WAIT = 2'd2
  } fb_state_t;

  // Record carried by EX and MEM
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } fb_rec_t;

  // Write-back only ever forwards; whether the result came from a load no
  // longer matters once it reaches WB, so that bit is not kept there.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
  } fb_wb_rec_t;

endpackage

// File: rtl/fb_fwd_ctrl_cmp.sv
// -----------------------------------------------------------------------------
// fb_fwd_cmp
// Forwarding select for one EX source operand.
// Ports:
//   rs                               : EX-stage source register index
//   mem_valid/mem_regwrite/mem_rd    : MEM-stage record
//   wb_valid/wb_regwrite/wb_rd       : WB-stage record
//   sel                              : 2-bit mux select (REG / ALU / MEM)
// The younger producer (MEM) wins over the older one (WB); x0 never forwards.
// -----------------------------------------------------------------------------
module fb_fwd_cmp
  import fb_fwd_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       mem_valid,
  input  logic       mem_regwrite,
  input  logic [4:0] mem_rd,
  input  logic       wb_valid,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_rd,
  output logic [1:0] sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = mem_valid && mem_regwrite && (mem_rd != 5'd0) && (mem_rd == rs);
  assign w_wb_hit  = wb_valid  && wb_regwrite  && (wb_rd  != 5'd0) && (wb_rd  == rs);

  always_comb begin
    sel = FB_FWD_REG;
    if (w_mem_hit)     sel = FB_FWD_ALU;
    else if (w_wb_hit) sel = FB_FWD_MEM;
  end

endmodule

// File: rtl/fb_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// fb_fwd_ctrl
// Forwarding and hazard controller for a 5-stage in-order pipeline.
// Tracks EX/MEM/WB stage records and produces:
//   fwd_a_sel/fwd_b_sel : EX operand forwarding selects (combinational)
//   stall_if/stall_id   : hold PC and IF/ID
//   freeze              : hold every pipeline register (load waiting on memory)
//   bubble_ex           : inject a NOP into ID/EX (load-use hazard)
//   lu_stall_cnt        : saturating count of load-use stall cycles
// Inputs: clk, rst_n (sync, active-low), ID-stage instruction fields,
//   mem_ready (load in MEM has completed), branch_flush (EX redirect).
// Priority: freeze > branch_flush > load-use.
// -----------------------------------------------------------------------------
module fb_fwd_ctrl
  import fb_fwd_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             mem_ready,
  input  logic             branch_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall_if,
  output logic             stall_id,
  output logic             freeze,
  output logic             bubble_ex,
  output logic [CNT_W-1:0] lu_stall_cnt
);

  fb_state_t        r_state;
  fb_rec_t          r_ex;
  logic [4:0]       r_ex_rs1;
  logic [4:0]       r_ex_rs2;
  fb_rec_t          r_mem;
  fb_wb_rec_t       r_wb;
  logic [CNT_W-1:0] r_cnt;

  logic       w_frz;
  logic       w_ex_hit;
  logic       w_lu;
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;

  // A load sitting in MEM without its data holds the whole pipe.
  assign w_frz = r_mem.valid && r_mem.memread && !mem_ready;

  assign w_ex_hit = r_ex.valid && r_ex.memread && (r_ex.rd != 5'd0) &&
                    ((r_ex.rd == id_rs1) || (r_ex.rd == id_rs2));

  // Freeze and flush both mask the load-use hazard.
  assign w_lu = id_valid && w_ex_hit && !w_frz && !branch_flush;

  fb_fwd_cmp u_cmp_a (
    .rs           (r_ex_rs1),
    .mem_valid    (r_mem.valid),
    .mem_regwrite (r_mem.regwrite),
    .mem_rd       (r_mem.rd),
    .wb_valid     (r_wb.valid),
    .wb_regwrite  (r_wb.regwrite),
    .wb_rd        (r_wb.rd),
    .sel          (w_sel_a)
  );

  fb_fwd_cmp u_cmp_b (
    .rs           (r_ex_rs2),
    .mem_valid    (r_mem.valid),
    .mem_regwrite (r_mem.regwrite),
    .mem_rd       (r_mem.rd),
    .wb_valid     (r_wb.valid),
    .wb_regwrite  (r_wb.regwrite),
    .wb_rd        (r_wb.rd),
    .sel          (w_sel_b)
  );

  // Outputs are forced quiet while reset is held, even before the first edge
  // has cleared the records.
  assign fwd_a_sel    = rst_n ? w_sel_a : FB_FWD_REG;
  assign fwd_b_sel    = rst_n ? w_sel_b : FB_FWD_REG;
  assign freeze       = rst_n && w_frz;
  assign stall_if     = rst_n && (w_frz || w_lu);
  assign stall_id     = rst_n && (w_frz || w_lu);
  assign bubble_ex    = rst_n && w_lu;
  assign lu_stall_cnt = r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= FB_ST_RUN;
      r_ex     <= '0;
      r_ex_rs1 <= '0;
      r_ex_rs2 <= '0;
      r_mem    <= '0;
      r_wb     <= '0;
      r_cnt    <= '0;
    end else begin
      // Exactly one LU_STALL cycle follows each accepted load-use hazard.
      if ((r_state == FB_ST_LU_STALL) && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + CNT_W'(1);

      if (w_frz) begin
        r_state <= FB_ST_MEM_WAIT;
      end else begin
        r_wb  <= '{valid: r_mem.valid, rd: r_mem.rd, regwrite: r_mem.regwrite};
        r_mem <= r_ex;
        // Flush kills the incoming ID instruction; load-use replaces it with
        // a bubble while IF/ID hold it for one more cycle.
        if (branch_flush || w_lu) begin
          r_ex     <= '0;
          r_ex_rs1 <= '0;
          r_ex_rs2 <= '0;
        end else begin
          r_ex     <= '{valid: id_valid, rd: id_rd, regwrite: id_regwrite,
                        memread: id_memread};
          r_ex_rs1 <= id_rs1;
          r_ex_rs2 <= id_rs2;
        end
        r_state <= w_lu ? FB_ST_LU_STALL : FB_ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_fb_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fb_fwd_ctrl
// Scoreboard bench: the driver applies one cycle of inputs, predicts that
// cycle's outputs from a pipeline model, and queues the prediction; the
// monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_fb_fwd_ctrl;

  localparam int CNT_W = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_regwrite, id_memread;
  logic             mem_ready, branch_flush;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic             stall_if, stall_id, freeze, bubble_ex;
  logic [CNT_W-1:0] lu_stall_cnt;

  always #5 clk = ~clk;

  fb_fwd_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .mem_ready    (mem_ready),
    .branch_flush (branch_flush),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .freeze       (freeze),
    .bubble_ex    (bubble_ex),
    .lu_stall_cnt (lu_stall_cnt)
  );

  typedef struct packed {
    logic [1:0]       a;
    logic [1:0]       b;
    logic             sif;
    logic             sid;
    logic             frz;
    logic             bub;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Pipeline model: one instruction descriptor per stage.
  typedef struct {
    bit v;
    int rd;
    int rs1;
    int rs2;
    bit rw;
    bit mr;
  } instr_t;

  instr_t m_ex, m_mem, m_wb;
  int     m_cnt;
  bit     m_pend;

  function automatic instr_t empty_instr();
    instr_t t;
    t.v = 0; t.rd = 0; t.rs1 = 0; t.rs2 = 0; t.rw = 0; t.mr = 0;
    return t;
  endfunction

  function automatic bit writes(instr_t t, int r);
    return t.v && t.rw && (t.rd != 0) && (t.rd == r);
  endfunction

  // Youngest in-flight producer wins.
  function automatic logic [1:0] fwd_of(int rs);
    if (writes(m_mem, rs)) return 2'b10;
    if (writes(m_wb, rs))  return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(string nm, int act, int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // One clock cycle of stimulus plus its prediction.
  task automatic step(bit rn, bit iv, int r1, int r2, int rd, bit rw, bit mr,
                      bit mrdy, bit fl);
    exp_t   e;
    instr_t id;
    bit     frz, lu;
    @(posedge clk);
    #1;
    rst_n        = rn;
    id_valid     = iv;
    id_rs1       = 5'(r1);
    id_rs2       = 5'(r2);
    id_rd        = 5'(rd);
    id_regwrite  = rw;
    id_memread   = mr;
    mem_ready    = mrdy;
    branch_flush = fl;
    id.v = iv; id.rd = rd; id.rs1 = r1; id.rs2 = r2; id.rw = rw; id.mr = mr;

    e = '0;
    e.cnt = CNT_W'(m_cnt);
    if (!rn) begin
      q.push_back(e);
      m_ex = empty_instr(); m_mem = empty_instr(); m_wb = empty_instr();
      m_cnt = 0; m_pend = 0;
    end else begin
      frz = m_mem.v && m_mem.mr && !mrdy;
      lu  = !frz && !fl && iv && m_ex.v && m_ex.mr && (m_ex.rd != 0) &&
            (m_ex.rd == r1 || m_ex.rd == r2);
      e.a   = fwd_of(m_ex.rs1);
      e.b   = fwd_of(m_ex.rs2);
      e.frz = frz;
      e.sif = frz || lu;
      e.sid = frz || lu;
      e.bub = lu;
      q.push_back(e);
      // The stall cycle after an accepted hazard is what gets counted.
      if (m_pend && m_cnt < CNT_MAX) m_cnt++;
      m_pend = lu;
      if (!frz) begin
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = (fl || lu) ? empty_instr() : id;
      end
    end
  endtask

  task automatic ins(int rd, int r1, int r2, bit rw, bit mr);
    step(1, 1, r1, r2, rd, rw, mr, 1, 0);
  endtask

  task automatic nop();
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  // Monitor: compare the oldest prediction on each falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("fwd_a_sel",    int'(fwd_a_sel),    int'(e.a));
      chk("fwd_b_sel",    int'(fwd_b_sel),    int'(e.b));
      chk("stall_if",     int'(stall_if),     int'(e.sif));
      chk("stall_id",     int'(stall_id),     int'(e.sid));
      chk("freeze",       int'(freeze),       int'(e.frz));
      chk("bubble_ex",    int'(bubble_ex),    int'(e.bub));
      chk("lu_stall_cnt", int'(lu_stall_cnt), int'(e.cnt));
    end
  end

  initial begin
    m_ex = empty_instr(); m_mem = empty_instr(); m_wb = empty_instr();
    m_cnt = 0; m_pend = 0;
    rst_n = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_regwrite = 0; id_memread = 0; mem_ready = 1; branch_flush = 0;
    @(posedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // add x5 ; sub x6 = x5 op x5 -> both operands from EX/MEM
    ins(5, 1, 2, 1, 0); ins(6, 5, 5, 1, 0); nop(); nop(); nop();
    // add x5 ; nop ; or x7 = x5 -> MEM/WB
    ins(5, 1, 2, 1, 0); nop(); ins(7, 5, 0, 1, 0); nop(); nop(); nop();
    // MEM and WB both write x5 -> EX/MEM wins
    ins(5, 1, 2, 1, 0); ins(5, 3, 4, 1, 0); ins(8, 5, 5, 1, 0); nop(); nop(); nop();
    // lw x5 ; add x6 = x5 (held in ID for the stall cycle)
    ins(5, 1, 0, 1, 1); ins(6, 5, 0, 1, 0); ins(6, 5, 0, 1, 0); nop(); nop(); nop();
    // load in MEM waiting three cycles on memory
    ins(5, 1, 0, 1, 1); ins(9, 2, 3, 1, 0);
    step(1, 1, 4, 4, 10, 1, 0, 0, 0);
    step(1, 1, 4, 4, 10, 1, 0, 0, 1);
    step(1, 1, 4, 4, 10, 1, 0, 0, 0);
    step(1, 1, 4, 4, 10, 1, 0, 1, 0);
    nop(); nop(); nop();
    // load-use coincident with branch flush
    ins(5, 1, 0, 1, 1); step(1, 1, 5, 5, 6, 1, 0, 1, 1); nop(); nop(); nop();
    // writes to x0 never forward
    ins(0, 1, 2, 1, 0); ins(6, 0, 0, 1, 0); ins(7, 0, 0, 1, 0); nop(); nop(); nop();
    // saturate the stall counter
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      ins(5, 1, 0, 1, 1); ins(6, 0, 5, 1, 0); ins(6, 0, 5, 1, 0);
    end
    nop(); nop();
    // reset while waiting on memory, and mid-stall
    ins(5, 1, 0, 1, 1); nop();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(); nop();
    ins(5, 1, 0, 1, 1); ins(6, 5, 0, 1, 0);
    step(0, 1, 5, 0, 6, 1, 0, 1, 0);
    nop(); nop();

    // Randomized traffic over a small register set to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) > 1, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    end
    nop();

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
